// File: rtl/dl11_mailbox_if.sv
// DCJ11 register-bus and Apple II slot signals for the DL11 mailbox.
// The master modport is the bus side (address latch, /DEVSEL synchroniser); the slave modport is the mailbox.
interface dl11_mailbox_if;
   logic [21:0] cpu_addr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic        cpu_byte;
   logic [15:0] cpu_wdata;
   logic        cpu_hit;
   logic [15:0] cpu_rdata;
   logic        a2_stb;
   logic        a2_rw;
   logic [7:0]  a2_addr;
   logic [7:0]  a2_wdata;
   logic [7:0]  a2_rdata;

   modport master (
      output cpu_addr, cpu_rd, cpu_wr, cpu_byte, cpu_wdata,
      output a2_stb, a2_rw, a2_addr, a2_wdata,
      input  cpu_hit, cpu_rdata, a2_rdata
   );

   modport slave (
      input  cpu_addr, cpu_rd, cpu_wr, cpu_byte, cpu_wdata,
      input  a2_stb, a2_rw, a2_addr, a2_wdata,
      output cpu_hit, cpu_rdata, a2_rdata
   );
endinterface

// File: rtl/dl11_mailbox.sv
// Multi-channel DL11 mailbox: per-channel RX (Apple->PDP) and TX (PDP->Apple) byte FIFOs.
// CPU reads are combinational, Apple reads land one cycle after the strobe; full FIFOs drop pushes.
module dl11_mailbox #(
   parameter int          NCHAN     = 2,
   parameter int          DEPTH     = 8,
   parameter logic [21:0] BASE_ADDR = 22'o17777560,
   parameter logic [7:0]  A2_BASE   = 8'h00
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_bus_init,
   dl11_mailbox_if.slave    bus,
   output logic [NCHAN-1:0] o_irq_rx,
   output logic [NCHAN-1:0] o_irq_tx
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]       r_rx_mem [NCHAN][DEPTH];
   logic [7:0]       r_tx_mem [NCHAN][DEPTH];
   logic [PW-1:0]    r_rx_wp [NCHAN];
   logic [PW-1:0]    r_rx_rp [NCHAN];
   logic [PW-1:0]    r_tx_wp [NCHAN];
   logic [PW-1:0]    r_tx_rp [NCHAN];
   logic [NCHAN-1:0] r_ovr, r_rie, r_tie, r_irq_rx, r_irq_tx;
   logic [7:0]       r_a2_rdata;

   logic [21:0]      w_cpu_off;
   logic             w_cpu_hit, w_cpu_odd_only;
   logic [1:0]       w_cpu_ch, w_cpu_reg, w_a2_ch, w_a2_reg;
   logic [7:0]       w_a2_off;
   logic             w_a2_hit;
   logic [PW-1:0]    w_rx_cnt [NCHAN];
   logic [PW-1:0]    w_tx_cnt [NCHAN];
   logic [6:0]       w_tx_cnt7 [NCHAN];
   logic [3:0]       w_tx_sat [NCHAN];
   logic [NCHAN-1:0] w_cpu_sel, w_a2_sel, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic [NCHAN-1:0] w_rx_req, w_tx_req, w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
   logic [NCHAN-1:0] w_ovr_set, w_flush, w_rie_wr, w_tie_wr;
   logic [15:0]      w_cpu_rdata;
   logic [7:0]       w_a2_rd_dat;

   // BASE_ADDR is even, so bit 0 of the offset is the byte lane
   assign w_cpu_off      = bus.cpu_addr - BASE_ADDR;
   assign w_cpu_hit      = w_cpu_off < 22'(8 * NCHAN);
   assign w_cpu_ch       = w_cpu_off[4:3];
   assign w_cpu_reg      = w_cpu_off[2:1];
   assign w_cpu_odd_only = bus.cpu_byte & w_cpu_off[0];
   assign w_a2_off       = bus.a2_addr - A2_BASE;
   assign w_a2_hit       = w_a2_off < 8'(4 * NCHAN);
   assign w_a2_ch        = w_a2_off[3:2];
   assign w_a2_reg       = w_a2_off[1:0];

   for (genvar g = 0; g < NCHAN; g++) begin : g_stat
      assign w_cpu_sel[g]  = w_cpu_hit && (w_cpu_ch == 2'(g));
      assign w_a2_sel[g]   = w_a2_hit && (w_a2_ch == 2'(g));
      assign w_rx_cnt[g]   = r_rx_wp[g] - r_rx_rp[g];
      assign w_tx_cnt[g]   = r_tx_wp[g] - r_tx_rp[g];
      assign w_rx_empty[g] = r_rx_wp[g] == r_rx_rp[g];
      assign w_tx_empty[g] = r_tx_wp[g] == r_tx_rp[g];
      assign w_rx_full[g]  = w_rx_cnt[g] == PW'(DEPTH);
      assign w_tx_full[g]  = w_tx_cnt[g] == PW'(DEPTH);
      assign w_tx_cnt7[g]  = 7'(w_tx_cnt[g]);
      assign w_tx_sat[g]   = (w_tx_cnt7[g] > 7'd15) ? 4'hF : w_tx_cnt7[g][3:0];
   end

   always_comb begin
      w_cpu_rdata = '0;
      w_a2_rd_dat = '0;
      w_rx_req = '0; w_tx_req = '0; w_rx_push = '0; w_rx_pop = '0;
      w_tx_push = '0; w_tx_pop = '0; w_ovr_set = '0; w_flush = '0;
      w_rie_wr = '0; w_tie_wr = '0;
      for (int n = 0; n < NCHAN; n++) begin
         if (w_cpu_sel[n]) begin
            case (w_cpu_reg)
               2'd0:    w_cpu_rdata = {r_ovr[n], 7'b0, !w_rx_empty[n], r_rie[n], 6'b0};
               2'd1:    if (!w_rx_empty[n])
                           w_cpu_rdata = {r_ovr[n], 7'b0, r_rx_mem[n][r_rx_rp[n][AW-1:0]]};
               2'd2:    w_cpu_rdata = {8'b0, !w_tx_full[n], r_tie[n], 6'b0};
               default: w_cpu_rdata = '0;
            endcase
         end
         if (w_a2_sel[n]) begin
            case (w_a2_reg)
               2'd0:    w_a2_rd_dat = {!w_tx_empty[n], w_rx_full[n], r_ovr[n], 1'b0, w_tx_sat[n]};
               2'd2:    if (!w_tx_empty[n]) w_a2_rd_dat = r_tx_mem[n][r_tx_rp[n][AW-1:0]];
               default: w_a2_rd_dat = '0;
            endcase
         end
         w_rie_wr[n] = w_cpu_sel[n] && bus.cpu_wr && (w_cpu_reg == 2'd0) && !w_cpu_odd_only;
         w_tie_wr[n] = w_cpu_sel[n] && bus.cpu_wr && (w_cpu_reg == 2'd2) && !w_cpu_odd_only;
         w_tx_req[n] = w_cpu_sel[n] && bus.cpu_wr && (w_cpu_reg == 2'd3) && !w_cpu_odd_only;
         w_rx_pop[n] = w_cpu_sel[n] && bus.cpu_rd && (w_cpu_reg == 2'd1) && !w_rx_empty[n];
         w_rx_req[n] = w_a2_sel[n] && bus.a2_stb && !bus.a2_rw && (w_a2_reg == 2'd1);
         w_flush[n]  = w_a2_sel[n] && bus.a2_stb && !bus.a2_rw && (w_a2_reg == 2'd3) && bus.a2_wdata[0];
         w_tx_pop[n] = w_a2_sel[n] && bus.a2_stb && bus.a2_rw && (w_a2_reg == 2'd2) && !w_tx_empty[n];
         // a same-cycle pop frees the slot, so a push into a full FIFO still lands
         w_rx_push[n] = w_rx_req[n] && (!w_rx_full[n] || w_rx_pop[n]);
         w_tx_push[n] = w_tx_req[n] && (!w_tx_full[n] || w_tx_pop[n]);
         w_ovr_set[n] = w_rx_req[n] && w_rx_full[n] && !w_rx_pop[n];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int n = 0; n < NCHAN; n++) begin
         if (i_rst || i_bus_init) begin
            r_rx_wp[n] <= '0; r_rx_rp[n] <= '0;
            r_tx_wp[n] <= '0; r_tx_rp[n] <= '0;
            r_ovr[n]   <= 1'b0; r_rie[n] <= 1'b0; r_tie[n] <= 1'b0;
         end else begin
            if (w_rie_wr[n]) r_rie[n] <= bus.cpu_wdata[6];
            if (w_tie_wr[n]) r_tie[n] <= bus.cpu_wdata[6];
            if (w_flush[n]) begin
               r_rx_wp[n] <= '0; r_rx_rp[n] <= '0;
               r_tx_wp[n] <= '0; r_tx_rp[n] <= '0;
               r_ovr[n]   <= 1'b0;
            end else begin
               if (w_rx_push[n]) r_rx_wp[n] <= r_rx_wp[n] + PW'(1);
               if (w_rx_pop[n])  r_rx_rp[n] <= r_rx_rp[n] + PW'(1);
               if (w_tx_push[n]) r_tx_wp[n] <= r_tx_wp[n] + PW'(1);
               if (w_tx_pop[n])  r_tx_rp[n] <= r_tx_rp[n] + PW'(1);
               if (w_rx_pop[n])       r_ovr[n] <= 1'b0;
               else if (w_ovr_set[n]) r_ovr[n] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int n = 0; n < NCHAN; n++) begin
         if (w_rx_push[n]) r_rx_mem[n][r_rx_wp[n][AW-1:0]] <= bus.a2_wdata;
         if (w_tx_push[n]) r_tx_mem[n][r_tx_wp[n][AW-1:0]] <= bus.cpu_wdata[7:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a2_rdata <= '0;
         r_irq_rx   <= '0;
         r_irq_tx   <= '0;
      end else begin
         r_irq_rx <= r_rie & ~w_rx_empty;
         r_irq_tx <= r_tie & ~w_tx_full;
         if (bus.a2_stb && bus.a2_rw && !i_bus_init) r_a2_rdata <= w_a2_rd_dat;
      end
   end

   assign bus.cpu_hit   = w_cpu_hit;
   assign bus.cpu_rdata = w_cpu_rdata;
   assign bus.a2_rdata  = r_a2_rdata;
   assign o_irq_rx      = r_irq_rx;
   assign o_irq_tx      = r_irq_tx;
endmodule

// File: tb/tb_dl11_mailbox.sv
// Scoreboarded bench for dl11_mailbox (NCHAN=2, DEPTH=8): stimulus queues expected reads, a negedge monitor checks them.
module tb_dl11_mailbox;
   localparam logic [21:0] BASE = 22'o17777560;
   localparam int K_CPU = 0, K_A2 = 1, K_IRQ = 2;

   typedef struct {
      int          kind;
      logic [16:0] val;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, bus_init, irq_probe, a2_pend;
   logic [1:0] irq_rx, irq_tx;
   exp_t       sbq[$];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   dl11_mailbox_if bus();

   dl11_mailbox #(.NCHAN(2), .DEPTH(8), .BASE_ADDR(BASE), .A2_BASE(8'h00)) dut (
      .i_clk(clk), .i_rst(rst), .i_bus_init(bus_init), .bus(bus),
      .o_irq_rx(irq_rx), .o_irq_tx(irq_tx)
   );

   function automatic logic [21:0] ca(int ch, int r);
      return BASE + 22'(8 * ch + 2 * r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(int kind, logic [16:0] val, string name);
      exp_t e;
      e.kind = kind; e.val = val; e.name = name;
      sbq.push_back(e);
   endtask

   task automatic check(int kind, logic [16:0] act);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL unexpected_output kind=%0d got=%h", kind, act);
      end else begin
         e = sbq.pop_front();
         if (e.kind != kind || e.val !== act) begin
            failures++;
            $display("FAIL %s kind=%0d got=%h expected=%h (expected kind %0d)",
                     e.name, kind, act, e.val, e.kind);
         end
      end
   endtask

   // CPU reads are checked while cpu_rd is high; Apple reads the cycle after the strobe
   always @(negedge clk) begin
      if (a2_pend) check(K_A2, {9'b0, bus.a2_rdata});
      a2_pend = bus.a2_stb && bus.a2_rw;
      if (bus.cpu_rd) check(K_CPU, {bus.cpu_hit, bus.cpu_rdata});
      if (irq_probe) check(K_IRQ, {13'b0, irq_tx, irq_rx});
   end

   task automatic cpu_rd_t(logic [21:0] addr, logic hit, logic [15:0] val, string name);
      expect_out(K_CPU, {hit, val}, name);
      bus.cpu_addr = addr;
      bus.cpu_rd   = 1'b1;
      tick();
      bus.cpu_rd   = 1'b0;
   endtask

   task automatic cpu_wr_t(logic [21:0] addr, logic [15:0] data, logic byte_wr);
      bus.cpu_addr  = addr;
      bus.cpu_wdata = data;
      bus.cpu_byte  = byte_wr;
      bus.cpu_wr    = 1'b1;
      tick();
      bus.cpu_wr    = 1'b0;
      bus.cpu_byte  = 1'b0;
   endtask

   task automatic a2_wr_t(logic [7:0] addr, logic [7:0] data);
      bus.a2_addr  = addr;
      bus.a2_wdata = data;
      bus.a2_rw    = 1'b0;
      bus.a2_stb   = 1'b1;
      tick();
      bus.a2_stb   = 1'b0;
   endtask

   task automatic a2_rd_t(logic [7:0] addr, logic [7:0] val, string name);
      expect_out(K_A2, {9'b0, val}, name);
      bus.a2_addr = addr;
      bus.a2_rw   = 1'b1;
      bus.a2_stb  = 1'b1;
      tick();
      bus.a2_stb  = 1'b0;
      bus.a2_rw   = 1'b0;
   endtask

   // expected value is {irq_tx[1:0], irq_rx[1:0]}
   task automatic probe(logic [3:0] val, string name);
      expect_out(K_IRQ, {13'b0, val}, name);
      irq_probe = 1'b1;
      tick();
      irq_probe = 1'b0;
   endtask

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog checks=%0d queued=%0d", checks, sbq.size());
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b1; bus_init = 1'b0; irq_probe = 1'b0; a2_pend = 1'b0;
      bus.cpu_addr = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_byte = 1'b0;
      bus.cpu_wdata = '0; bus.a2_stb = 1'b0; bus.a2_rw = 1'b0;
      bus.a2_addr = '0; bus.a2_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "rst_rcsr0");
      cpu_rd_t(ca(1, 2), 1'b1, 16'h0080, "rst_xcsr1");
      a2_rd_t(8'h00, 8'h00, "rst_stat0");
      probe(4'b0000, "rst_irq");

      // single byte Apple -> PDP
      a2_wr_t(8'h01, 8'h41);
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0080, "t1_rcsr_done");
      cpu_rd_t(ca(0, 1), 1'b1, 16'h0041, "t1_rbuf");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "t1_rcsr_empty");

      // TX overfill on channel 1
      for (int i = 0; i < 9; i++) begin
         cpu_wr_t(ca(1, 3), 16'(16 + i), 1'b0);
         if (i == 6) cpu_rd_t(ca(1, 2), 1'b1, 16'h0080, "t2_ready_after7");
         if (i == 7) cpu_rd_t(ca(1, 2), 1'b1, 16'h0000, "t2_ready_after8");
      end
      a2_rd_t(8'h04, 8'h88, "t2_stat");
      for (int i = 0; i < 8; i++) a2_rd_t(8'h06, 8'(16 + i), "t2_txd_order");
      a2_rd_t(8'h06, 8'h00, "t2_txd_empty");
      a2_rd_t(8'h04, 8'h00, "t2_stat_empty");
      cpu_wr_t(ca(1, 3) + 22'd1, 16'h7700, 1'b1);
      a2_rd_t(8'h04, 8'h00, "t2_odd_byte_ignored");
      cpu_wr_t(ca(1, 3), 16'h005A, 1'b1);
      a2_rd_t(8'h04, 8'h81, "t2_even_byte_stat");
      a2_rd_t(8'h06, 8'h5A, "t2_even_byte_data");

      // RX overrun on channel 0
      for (int i = 0; i < 9; i++) a2_wr_t(8'h01, 8'(32 + i));
      cpu_rd_t(ca(0, 0), 1'b1, 16'h8080, "t3_rcsr_ovr");
      a2_rd_t(8'h00, 8'h60, "t3_stat_full_ovr");
      cpu_rd_t(ca(0, 1), 1'b1, 16'h8020, "t3_rbuf_ovr");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0080, "t3_ovr_cleared");
      for (int i = 1; i < 8; i++) cpu_rd_t(ca(0, 1), 1'b1, 16'(32 + i), "t3_drain");
      cpu_rd_t(ca(0, 1), 1'b1, 16'h0000, "t3_rbuf_empty");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "t3_rcsr_empty");

      // full FIFO, push and pop in the same cycle
      for (int i = 0; i < 8; i++) a2_wr_t(8'h01, 8'(48 + i));
      expect_out(K_CPU, {1'b1, 16'h0030}, "t5_pop_head");
      bus.cpu_addr = ca(0, 1); bus.cpu_rd = 1'b1;
      bus.a2_addr = 8'h01; bus.a2_wdata = 8'h38; bus.a2_rw = 1'b0; bus.a2_stb = 1'b1;
      tick();
      bus.cpu_rd = 1'b0; bus.a2_stb = 1'b0;
      a2_rd_t(8'h00, 8'h40, "t5_stat_full_no_ovr");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0080, "t5_rcsr");
      for (int i = 1; i < 9; i++) cpu_rd_t(ca(0, 1), 1'b1, 16'(48 + i), "t5_order");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "t5_empty");

      // RX interrupt timing
      cpu_wr_t(ca(0, 0), 16'h0040, 1'b0);
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0040, "t4_rie_set");
      probe(4'b0000, "t4_irq_idle");
      a2_wr_t(8'h01, 8'h55);
      probe(4'b0000, "t4_irq_lag");
      probe(4'b0001, "t4_irq_set");
      cpu_rd_t(ca(0, 1), 1'b1, 16'h0055, "t4_rbuf");
      probe(4'b0001, "t4_irq_hold");
      probe(4'b0000, "t4_irq_drop");

      // TX interrupt, then bus INIT with 3 bytes held
      cpu_wr_t(ca(1, 2), 16'h0040, 1'b0);
      tick();
      probe(4'b1000, "t6_irq_tx1");
      for (int i = 0; i < 3; i++) cpu_wr_t(ca(1, 3), 16'(96 + i), 1'b0);
      a2_rd_t(8'h04, 8'h83, "t6_stat3");
      bus_init = 1'b1;
      tick();
      bus_init = 1'b0;
      a2_rd_t(8'h04, 8'h00, "t6_stat_init");
      cpu_rd_t(ca(1, 2), 1'b1, 16'h0080, "t6_xcsr_init");
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "t6_rcsr_init");
      probe(4'b0000, "t6_irq_init");

      // INIT wins over a same-cycle Apple push
      bus.a2_addr = 8'h01; bus.a2_wdata = 8'h77; bus.a2_rw = 1'b0; bus.a2_stb = 1'b1;
      bus_init = 1'b1;
      tick();
      bus.a2_stb = 1'b0; bus_init = 1'b0;
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "init_priority");

      // decode edges and write-protect cases
      cpu_rd_t(BASE - 22'd2, 1'b0, 16'h0000, "below_range");
      cpu_rd_t(BASE + 22'd16, 1'b0, 16'h0000, "above_range");
      cpu_rd_t(ca(1, 3), 1'b1, 16'h0000, "xbuf_reads_zero");
      a2_rd_t(8'h08, 8'h00, "a2_out_of_range");
      a2_rd_t(8'h01, 8'h00, "a2_rxd_read_zero");
      cpu_wr_t(ca(0, 0) + 22'd1, 16'h4040, 1'b1);
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0000, "rcsr_hibyte_ignored");
      cpu_wr_t(ca(0, 0), 16'h0040, 1'b1);
      cpu_rd_t(ca(0, 0), 1'b1, 16'h0040, "rcsr_lobyte_write");

      repeat (3) tick();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL leftover_expectations got=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
